// File: rtl/femto_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : femto_bus_pkg
// Description : Shared bus encodings, slave FSM state type, byte-lane helper.
// Revision    : 1.0 - initial release
// ============================================================================
package femto_bus_pkg;

  localparam logic [1:0] HSIZE_BYTE    = 2'd0;
  localparam logic [1:0] HSIZE_HALF    = 2'd1;
  localparam logic [1:0] HSIZE_WORD    = 2'd2;
  localparam logic [1:0] HSIZE_ILLEGAL = 2'd3;

  localparam logic HPROT_FETCH = 1'b0;
  localparam logic HPROT_DATA  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_WR      = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_ERR1    = 3'd4,
    ST_ERR2    = 3'd5
  } state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << lo;
      HSIZE_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_sram_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : dbus_sram_slave_if
// Description : Data-bus signal bundle between master and SRAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface dbus_sram_slave_if;
  logic        htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [1:0]  hsize;
  logic        hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output htrans, hwrite, haddr, hsize, hprot, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  htrans, hwrite, haddr, hsize, hprot, hwdata,
    output hrdata, hready, hresp
  );
endinterface
`default_nettype wire

// File: rtl/dbus_sram_mem.sv
`default_nettype none
// ============================================================================
// Module      : dbus_sram_mem
// Description : Single-port synchronous word RAM, byte enables, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_sram_mem #(
  parameter int AW = 10
) (
  input  wire logic          clk,
  input  wire logic          i_en,
  input  wire logic          i_we,
  input  wire logic [3:0]    i_be,
  input  wire logic [AW-1:0] i_addr,
  input  wire logic [31:0]   i_wdata,
  output logic      [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata;

  // Read data only moves on a read access, so it holds between reads.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < 4; i++) begin
          if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dbus_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : dbus_sram_slave
// Description : Zero-wait data-bus SRAM slave with error checks and RAW stall.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_sram_slave
  import femto_bus_pkg::*;
#(
  parameter int SIZE_BYTES = 4096,
  parameter bit EXEC_EN    = 1'b1
) (
  input wire logic          clk,
  input wire logic          rstn,
  dbus_sram_slave_if.slave  bus
);

  localparam int          c_aw   = $clog2(SIZE_BYTES) - 2;
  localparam logic [32:0] c_size = 33'(SIZE_BYTES);

  state_t            r_state;
  state_t            w_next;
  logic [c_aw-1:0]   r_addr;
  logic [3:0]        r_be;
  logic              w_hready;
  logic              w_accept;
  logic              w_err;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [c_aw-1:0]   w_mem_addr;
  logic [31:0]       w_rdata;

  assign w_hready = !((r_state == ST_RD_WAIT) || (r_state == ST_ERR1));
  assign w_accept = bus.htrans & w_hready;

  always_comb begin
    w_err = 1'b0;
    if ({1'b0, bus.haddr} >= c_size) w_err = 1'b1;
    case (bus.hsize)
      HSIZE_HALF:    if (bus.haddr[0])          w_err = 1'b1;
      HSIZE_WORD:    if (bus.haddr[1:0] != 2'b0) w_err = 1'b1;
      HSIZE_ILLEGAL: w_err = 1'b1;
      default:       ;
    endcase
    if (!EXEC_EN && (bus.hprot == HPROT_FETCH)) w_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_be    <= 4'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= bus.haddr[c_aw+1:2];
        r_be   <= byte_en(bus.hsize, bus.haddr[1:0]);
      end
    end
  end

  always_comb begin
    w_next     = ST_IDLE;
    w_mem_en   = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_addr = r_addr;
    case (r_state)
      ST_RD_WAIT: begin
        w_next   = ST_RD;
        w_mem_en = 1'b1;
      end
      ST_ERR1: w_next = ST_ERR2;
      default: begin
        if (r_state == ST_WR) begin
          w_mem_en = 1'b1;
          w_mem_we = 1'b1;
        end
        if (w_accept) begin
          if (w_err)            w_next = ST_ERR1;
          else if (bus.hwrite)  w_next = ST_WR;
          else if (r_state == ST_WR) w_next = ST_RD_WAIT;
          else begin
            // Port is free: issue the read at the accepting edge.
            w_next     = ST_RD;
            w_mem_en   = 1'b1;
            w_mem_addr = bus.haddr[c_aw+1:2];
          end
        end
      end
    endcase
    // A write or read landing on a reset edge is dropped.
    if (!rstn) w_mem_en = 1'b0;
  end

  dbus_sram_mem #(
    .AW (c_aw)
  ) u_mem (
    .clk     (clk),
    .i_en    (w_mem_en),
    .i_we    (w_mem_we),
    .i_be    (r_be),
    .i_addr  (w_mem_addr),
    .i_wdata (bus.hwdata),
    .o_rdata (w_rdata)
  );

  assign bus.hready = w_hready;
  assign bus.hresp  = (r_state == ST_ERR1) || (r_state == ST_ERR2);
  assign bus.hrdata = w_rdata;

endmodule
`default_nettype wire
